int_fp_mul_pipe: RTL and testbench
==================================

// Module: int_fp_mul_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined multiplier, integer or floating point, selected per transaction by in_mode.
//  Generalises the fixed 16-bit int_fp_mul: configurable EXP_W/MAN_W, valid/ready flow control, tag pass-through.
//  Sits between the operand issue logic and result writeback in the datapath; sustains one result per cycle.
// PARAMETERS
//  EXP_W  5   exponent width; W = 1+EXP_W+MAN_W (default 16, IEEE half layout)
//  MAN_W  10  stored mantissa (fraction) width
//  TAG_W  4   width of opaque tag carried alongside each transaction
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operand transaction valid
//  in_ready   out  1      block accepts transaction this cycle
//  in_mode    in   1      0 = signed integer, 1 = floating point
//  in_a       in   W      operand A
//  in_b       in   W      operand B
//  in_tag     in   TAG_W  user tag, returned unchanged with result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_c      out  W      product
//  out_error  out  1      overflow (int/FP) or invalid (FP NaN)
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all stage valids cleared, out_valid=0, out_c=0, out_error=0, out_tag=0;
//   in_ready=0 while rst_n=0. Reset mid-operation discards all in-flight transactions; none emerge.
//  Handshake: transfer on in_valid&in_ready / out_valid&out_ready. Stages S1 unpack/classify, S2 multiply,
//   S3 normalise/pack (= output register). Stage k loads when empty or its contents move on this cycle.
//   in_ready = !v1 | advance1 (combinational from out_ready through stage valids; no bubble, 1 txn/cycle).
//  Latency: 3 cycles accept->out_valid with out_ready=1. out_c/out_error/out_tag stable while out_valid&!out_ready.
//  Order preserved; mode and tag travel with their operands (mixed-mode streams allowed back-to-back).
//  Integer mode: A,B signed two's complement W bits; out_c = low W bits of full 2W product;
//   out_error=1 iff product outside [-2^(W-1), 2^(W-1)-1].
//  FP mode: BIAS = 2^(EXP_W-1)-1; sign = sa^sb; rounding = truncate (toward zero).
//   exp==0 inputs (zero/subnormal) treated as zero; zero outputs are signed zero (sign=sa^sb).
//   Either NaN, or Inf*zero -> canonical NaN {0, all-ones exp, MSB fraction 1, rest 0}, out_error=1.
//   Inf*nonzero finite or Inf*Inf -> signed Inf, out_error=0.
//   Normal: e = ea+eb-BIAS (EXP_W+2 bit signed); m = {1,fa}*{1,fb} (2*MAN_W+2 bits);
//    if m MSB set: frac = m[2MAN_W:MAN_W+1], e+=1; else frac = m[2MAN_W-1:MAN_W].
//    e >= 2^EXP_W-1 -> signed Inf, out_error=1 (overflow). e <= 0 -> signed zero, out_error=0 (flush).
//  Simultaneous accept and emit in one cycle is the normal streaming case; full pipe with out_ready=0
//   drives in_ready=0 and holds all stages.
// TESTING (defaults, W=16)
//  FP 0x3C00*0x4000 (1.0*2.0) -> out_c=0x4000, out_error=0, out_valid exactly 3 cycles after accept
//  FP 0x3E00*0x3E00 (1.5*1.5) -> 0x4080; FP 0xBC00*0x3C00 -> 0xBC00; FP 0x0001*0x3C00 -> 0x0000
//  FP 0x7BFF*0x4000 -> 0x7C00 err=1; FP 0x7C00*0x0000 -> 0x7E00 err=1; FP 0x7C00*0xC000 -> 0xFC00 err=0
//  INT 0xFFFE*0x0003 -> 0xFFFA err=0; INT 0x0100*0x0100 -> 0x0000 err=1; INT 0x8000*0xFFFF -> 0x8000 err=1
//  Stream 8 mixed-mode txns, tags 0..7, out_ready toggled randomly -> in-order results, tags 0..7, no loss/dup
//  Fill pipe, out_ready=0 -> in_ready=0, outputs stable; assert rst_n=0 one cycle -> out_valid=0, nothing emerges

Source files
------------

// File: rtl/int_fp_mul_pipe.sv
// Three-stage pipelined multiplier. Each transaction selects signed-integer or
// floating-point mode. FP uses an IEEE-like layout {sign, EXP_W exponent,
// MAN_W fraction}, truncating rounding, and zero-flushed subnormals.
//
// Flow control: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. valid must not depend on ready. A stage loads when
// it is empty or when its current contents move on in the same cycle, so the
// pipe streams one transaction per cycle with no bubbles.
module int_fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_c,
    output logic                 out_error,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = 2 * MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic        [EW-1:0] BIAS_U = EW'(BIAS);

    // Stage valids and per-stage load enables
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic ld1, ld2, ld3;

    // S1: registered operands plus FP special-case classification
    logic           mode1_q, mode1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic [W-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic           sign1_q, sign1_d;
    logic           nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;

    // S2: raw products and the biased exponent sum
    logic           mode2_q, mode2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    logic           sign2_q, sign2_d;
    logic           nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
    logic [2*W-1:0] prod2_q, prod2_d;
    logic [MW-1:0]  man2_q, man2_d;
    logic signed [EW-1:0] exp2_q, exp2_d;

    // S3: packed result, which is also the output register
    logic [W-1:0]   c3_q, c3_d;
    logic           err3_q, err3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    // Low product bits are discarded by truncating rounding
    logic unused_man_bits;
    assign unused_man_bits = ^man2_q[MAN_W-1:0];

    // Backpressure chain: each stage may load when empty or when it drains this cycle
    always_comb begin
        ld3      = !v3_q || out_ready;
        ld2      = !v2_q || ld3;
        ld1      = !v1_q || ld2;
        in_ready = rst_n && ld1;
    end

    // S1: capture the operands and classify the FP special cases
    always_comb begin
        logic [EXP_W-1:0] a_exp, b_exp;
        logic [MAN_W-1:0] a_frac, b_frac;
        logic a_ones, b_ones, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
        logic r_nan, r_inf;

        a_exp  = in_a[W-2:MAN_W];
        b_exp  = in_b[W-2:MAN_W];
        a_frac = in_a[MAN_W-1:0];
        b_frac = in_b[MAN_W-1:0];
        a_ones = &a_exp;
        b_ones = &b_exp;
        a_zero = ~|a_exp;
        b_zero = ~|b_exp;
        a_nan  = a_ones && (|a_frac);
        b_nan  = b_ones && (|b_frac);
        a_inf  = a_ones && !(|a_frac);
        b_inf  = b_ones && !(|b_frac);
        r_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        r_inf  = !r_nan && (a_inf || b_inf);

        v1_d    = v1_q;
        mode1_d = mode1_q;
        tag1_d  = tag1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        sign1_d = sign1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        zero1_d = zero1_q;
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                mode1_d = in_mode;
                tag1_d  = in_tag;
                a1_d    = in_a;
                b1_d    = in_b;
                sign1_d = in_a[W-1] ^ in_b[W-1];
                nan1_d  = r_nan;
                inf1_d  = r_inf;
                zero1_d = !r_nan && !r_inf && (a_zero || b_zero);
            end
        end
    end

    // S2: integer product, mantissa product and exponent sum
    always_comb begin
        logic signed [2*W-1:0] pa, pb;
        logic [MW-1:0] ma, mb;

        pa = {{W{a1_q[W-1]}}, a1_q};
        pb = {{W{b1_q[W-1]}}, b1_q};
        ma = MW'({1'b1, a1_q[MAN_W-1:0]});
        mb = MW'({1'b1, b1_q[MAN_W-1:0]});

        v2_d    = v2_q;
        mode2_d = mode2_q;
        tag2_d  = tag2_q;
        sign2_d = sign2_q;
        nan2_d  = nan2_q;
        inf2_d  = inf2_q;
        zero2_d = zero2_q;
        prod2_d = prod2_q;
        man2_d  = man2_q;
        exp2_d  = exp2_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                mode2_d = mode1_q;
                tag2_d  = tag1_q;
                sign2_d = sign1_q;
                nan2_d  = nan1_q;
                inf2_d  = inf1_q;
                zero2_d = zero1_q;
                prod2_d = pa * pb;
                man2_d  = ma * mb;
                exp2_d  = EW'(a1_q[W-2:MAN_W]) + EW'(b1_q[W-2:MAN_W]) - BIAS_U;
            end
        end
    end

    // S3: normalise, range-check and pack the result into the output register
    always_comb begin
        logic signed [EW-1:0] e_adj;
        logic [MAN_W-1:0] frac;
        logic [W:0]       hi;
        logic [W-1:0]     fp_c;
        logic             fp_err;

        if (man2_q[MW-1]) begin
            frac  = man2_q[2*MAN_W:MAN_W+1];
            e_adj = exp2_q + EW'(1);
        end else begin
            frac  = man2_q[2*MAN_W-1:MAN_W];
            e_adj = exp2_q;
        end

        fp_err = 1'b0;
        if (nan2_q) begin
            fp_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            fp_err = 1'b1;
        end else if (inf2_q) begin
            fp_c = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2_q) begin
            fp_c = {sign2_q, {(W-1){1'b0}}};
        end else if (e_adj >= EMAX_S) begin
            fp_c   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fp_err = 1'b1;
        end else if (e_adj <= 0) begin
            fp_c = {sign2_q, {(W-1){1'b0}}};
        end else begin
            fp_c = {sign2_q, e_adj[EXP_W-1:0], frac};
        end

        // Integer result fits iff the top W+1 product bits are all equal
        hi = prod2_q[2*W-1:W-1];

        v3_d   = v3_q;
        c3_d   = c3_q;
        err3_d = err3_q;
        tag3_d = tag3_q;
        if (ld3) begin
            v3_d = v2_q;
            if (v2_q) begin
                tag3_d = tag2_q;
                if (mode2_q) begin
                    c3_d   = fp_c;
                    err3_d = fp_err;
                end else begin
                    c3_d   = prod2_q[W-1:0];
                    err3_d = !((&hi) || (~|hi));
                end
            end
        end
    end

    // Pipeline registers; reset drops every in-flight transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= 1'b0;
            tag1_q  <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            sign1_q <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            mode2_q <= 1'b0;
            tag2_q  <= '0;
            sign2_q <= 1'b0;
            nan2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            prod2_q <= '0;
            man2_q  <= '0;
            exp2_q  <= '0;
            c3_q    <= '0;
            err3_q  <= 1'b0;
            tag3_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            mode1_q <= mode1_d;
            tag1_q  <= tag1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            sign1_q <= sign1_d;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            mode2_q <= mode2_d;
            tag2_q  <= tag2_d;
            sign2_q <= sign2_d;
            nan2_q  <= nan2_d;
            inf2_q  <= inf2_d;
            zero2_q <= zero2_d;
            prod2_q <= prod2_d;
            man2_q  <= man2_d;
            exp2_q  <= exp2_d;
            c3_q    <= c3_d;
            err3_q  <= err3_d;
            tag3_q  <= tag3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_c     = c3_q;
    assign out_error = err3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_int_fp_mul_pipe.sv
// Bench for int_fp_mul_pipe: directed vector table, stall/reset sequence, and
// randomized mixed-mode streams checked against an arithmetic reference model.
module tb_int_fp_mul_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int TAG_W = 4;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX  = (1 << EXP_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_mode = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [W-1:0] out_c;
    logic out_error;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    int_fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_error(out_error), .out_tag(out_tag)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic mon_en = 1'b0;
    logic [W+TAG_W:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] fp_pack(input logic s, input int e, input int f);
        logic [W-1:0] v;
        v = W'(f) | (W'(e) << MAN_W);
        v[W-1] = s;
        return v;
    endfunction

    // Returns {error, product}
    function automatic logic [W:0] ref_mul(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb, p, lo, hi;
        int ea, eb, e, fa, fb, f;
        logic s, a_nan, b_nan, a_inf, b_inf;
        logic [W-1:0] c;
        if (!mode) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            lo = -(longint'(1) << (W - 1));
            hi = (longint'(1) << (W - 1)) - 1;
            c  = p[W-1:0];
            return {(p < lo) || (p > hi), c};
        end
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        fa = int'(a[MAN_W-1:0]);
        fb = int'(b[MAN_W-1:0]);
        s  = a[W-1] ^ b[W-1];
        a_nan = (ea == EMAX) && (fa != 0);
        b_nan = (eb == EMAX) && (fb != 0);
        a_inf = (ea == EMAX) && (fa == 0);
        b_inf = (eb == EMAX) && (fb == 0);
        if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0))
            return {1'b1, fp_pack(1'b0, EMAX, 1 << (MAN_W - 1))};
        if (a_inf || b_inf)
            return {1'b0, fp_pack(s, EMAX, 0)};
        if (ea == 0 || eb == 0)
            return {1'b0, fp_pack(s, 0, 0)};
        p = longint'(fa + (1 << MAN_W)) * longint'(fb + (1 << MAN_W));
        e = ea + eb - BIAS;
        if (p >= (longint'(1) << (2 * MAN_W + 1))) begin
            p = p / 2;
            e = e + 1;
        end
        f = int'(p / (longint'(1) << MAN_W)) - (1 << MAN_W);
        if (e >= EMAX) return {1'b1, fp_pack(s, EMAX, 0)};
        if (e <= 0)    return {1'b0, fp_pack(s, 0, 0)};
        return {1'b0, fp_pack(s, e, f)};
    endfunction

    function automatic logic [W-1:0] rand_op(input logic mode);
        logic [W-1:0] v;
        int k;
        v = W'($urandom);
        k = int'($urandom_range(0, 9));
        if (!mode) begin
            if (k >= 4) v = W'(int'($urandom_range(0, 600)) - 300);
        end else begin
            if (k < 6) v[W-2:MAN_W] = EXP_W'($urandom_range(6, 24));
            else if (k == 6) begin
                v[W-2:MAN_W] = '1;
                if ($urandom_range(0, 1) == 0) v[MAN_W-1:0] = '0;
            end else if (k == 7) v[W-2:MAN_W] = '0;
        end
        return v;
    endfunction

    // ---------------- monitor: push on accept, compare on emit ----------------
    always @(negedge clk) begin
        logic [W+TAG_W:0] exp_w;
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                n_popped++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: got tag 0x%0h c 0x%0h, required no result", out_tag, out_c);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("stream_tag_err_c", 64'({out_tag, out_error, out_c}), 64'(exp_w));
                end
            end
            if (in_valid && in_ready) begin
                n_pushed++;
                exp_q.push_back({in_tag, ref_mul(in_mode, in_a, in_b)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_one(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TAG_W-1:0] tag, output logic [W-1:0] c,
                            output logic err, output logic [TAG_W-1:0] t, output int lat);
        int guard;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b; in_tag = tag;
        out_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        c = out_c; err = out_error; t = out_tag;
    endtask

    task automatic drive_stream(input int n, input bit alt_mode);
        int guard;
        bit acc;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                out_ready = $urandom_range(0, 1) != 0;
            end
            in_valid = 1'b1;
            in_mode  = alt_mode ? i[0] : ($urandom_range(0, 1) != 0);
            in_a     = rand_op(in_mode);
            in_b     = rand_op(in_mode);
            in_tag   = TAG_W'(i);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = in_ready;
                if (!acc) begin
                    @(posedge clk); #1;
                    out_ready = $urandom_range(0, 1) != 0;
                    guard++;
                end
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_accept_timeout: got in_ready 0 for %0d cycles, required 1", guard);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [W-1:0] c, c_hold;
        logic err;
        logic [TAG_W-1:0] t, t_hold;
        int lat, acc, seen;

        vecs[0]  = '{1'b1, 16'h3C00, 16'h4000, 16'h4000, 1'b0};
        vecs[1]  = '{1'b1, 16'h3E00, 16'h3E00, 16'h4080, 1'b0};
        vecs[2]  = '{1'b1, 16'hBC00, 16'h3C00, 16'hBC00, 1'b0};
        vecs[3]  = '{1'b1, 16'h0001, 16'h3C00, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1};
        vecs[5]  = '{1'b1, 16'h7C00, 16'h0000, 16'h7E00, 1'b1};
        vecs[6]  = '{1'b1, 16'h7C00, 16'hC000, 16'hFC00, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFE, 16'h0003, 16'hFFFA, 1'b0};
        vecs[8]  = '{1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1};
        vecs[10] = '{1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b0};
        vecs[11] = '{1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0};
        vecs[12] = '{1'b1, 16'h7E01, 16'h3C00, 16'h7E00, 1'b1};
        vecs[13] = '{1'b1, 16'h8400, 16'h0400, 16'h8000, 1'b0};
        vecs[14] = '{1'b1, 16'h7C00, 16'h7C00, 16'h7C00, 1'b0};
        vecs[15] = '{1'b1, 16'hC000, 16'h0000, 16'h8000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_c", 64'(out_c), 64'd0);
        check("reset_out_error", 64'(out_error), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Directed table, one transaction at a time
        for (int i = 0; i < 16; i++) begin
            send_one(vecs[i].mode, vecs[i].a, vecs[i].b, TAG_W'(i), c, err, t, lat);
            check($sformatf("vec%0d_c", i), 64'(c), 64'(vecs[i].c));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
            check($sformatf("vec%0d_tag", i), 64'(t), 64'(i));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end
        @(posedge clk); #1;

        // Fill pipe with out_ready low: exactly three accepted, then stall
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_mode = 1'b0;
            in_a = W'(i + 2); in_b = 16'h0003; in_tag = TAG_W'(8 + i);
            @(negedge clk);
            if (in_ready) acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_accepted", 64'(acc), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_c", 64'(out_c), 64'h6);
        check("stall_out_tag", 64'(out_tag), 64'h8);
        c_hold = out_c;
        t_hold = out_tag;
        repeat (4) @(posedge clk);
        #1;
        check("stall_hold_c", 64'(out_c), 64'(c_hold));
        check("stall_hold_tag", 64'(out_tag), 64'(t_hold));
        check("stall_hold_valid", 64'(out_valid), 64'd1);

        // One-cycle reset while full: nothing may emerge afterwards
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_nothing_emerges", 64'(seen), 64'd0);

        // Mixed-mode stream of 8, tags 0..7, random backpressure
        mon_en = 1'b1;
        n_pushed = 0;
        n_popped = 0;
        drive_stream(8, 1'b1);
        drain("stream8_drain");
        check("stream8_pushed", 64'(n_pushed), 64'd8);
        check("stream8_popped", 64'(n_popped), 64'd8);

        // Long random stream
        n_pushed = 0;
        n_popped = 0;
        drive_stream(300, 1'b0);
        drain("random_drain");
        check("random_count", 64'(n_popped), 64'(n_pushed));
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
